uart_param: RTL and testbench
=============================

# uart_param

Parametrised UART core, the next-generation replacement for the fixed 8N1 transmitter/receiver pair. It provides a full-duplex serial link with compile-time data width, parity mode, stop-bit count and baud divisor. The transmit side uses a ready/valid handshake. The receive side oversamples the line and flags parity and framing errors. It sits between the system-side byte interface and the off-chip serial pins.

## Interface
- `DIV`, 1: clock cycles per oversample tick (≥1).
- `OVERSAMPLE`, 16: ticks per bit (even, ≥4); bit time BIT_CLKS = DIV*OVERSAMPLE clocks.
- `DATA_BITS`, 8: data bits per frame (5–9), LSB first.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: transmit request.
- `tx_data` in DATA_BITS: word to send; sampled only on handshake.
- `tx_ready` out 1: high when the transmitter is idle and can accept a word.
- `serialOutput` out 1: TX line; idles high.
- `serialInput` in 1: RX line (asynchronous).
- `rx_data` out DATA_BITS: last received word.
- `rx_valid` out 1: one-cycle pulse when a frame completes.
- `rx_parity_err` out 1: parity mismatch on the last frame; always 0 when PARITY=0.
- `rx_frame_err` out 1: stop bit sampled low on the last frame.

## Operation
- Reset values: serialOutput=1, tx_ready=1, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0. The 2-FF input synchronizer resets to 1. Both FSMs reset to IDLE. Reset mid-frame aborts the frame immediately and no partial rx_valid is produced.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - Handshake occurs when tx_valid && tx_ready on an edge. On handshake, tx_data is latched, tx_ready drops and the bit counter clears.
  - Each state/bit holds serialOutput for exactly BIT_CLKS clocks.
  - DATA shifts out DATA_BITS bits, LSB first.
  - Parity bit: XOR of data bits for even, inverted for odd.
  - STOP lasts STOP_BITS*BIT_CLKS clocks at 1.
  - tx_ready rises on the last clock of STOP. A back-to-back handshake on that edge starts the next START with no idle gap.
  - tx_valid is ignored while tx_ready=0.
- Tick generator: free-running counter 0..DIV-1; the RX tick is asserted when count==DIV-1. When DIV=1 the tick is asserted every cycle.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE, with an added BREAK state.
  - IDLE: the synchronized line going low moves the FSM to START.
  - START: after OVERSAMPLE/2 ticks, the line is re-sampled. If it is high, the event is a glitch and the FSM returns to IDLE with no output. If it is low, the FSM proceeds.
  - Each later bit is sampled at mid-bit, every OVERSAMPLE ticks. Data is assembled LSB first.
  - PARITY compares the received parity bit with the computed parity.
  - STOP samples only the first stop bit; a second stop bit is not checked by RX.
  - At the STOP sample: rx_data, rx_parity_err and rx_frame_err update, and rx_valid pulses for 1 cycle. The pulse is issued even when an error is flagged.
  - If the stop bit is 0, the FSM enters BREAK and waits for the synchronized line to be high before returning to IDLE. This prevents false starts during a line break.
- rx_data and the error flags hold their values until the next rx_valid. There is no receive buffering: the consumer must take rx_data before the next frame completes, or it is overwritten.
- TX and RX are fully independent; simultaneous activity is permitted.

## Timing
- TX latency: handshake at edge N → serialOutput=0 from N+1.
- TX frame length: (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS) * BIT_CLKS clocks. tx_ready is low for exactly that many cycles minus 1.
- RX latency: rx_valid pulses 2 (synchronizer) + ≤DIV (tick phase) cycles after the nominal centre of the first stop bit.
- The receiver tolerates a ±2% baud mismatch with OVERSAMPLE=16.
- Error flags and rx_data change only in the same cycle as rx_valid.

## Test plan
- 8N1, DIV=1, OVERSAMPLE=16: send 0xA5 → serialOutput = 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks; tx_ready low for 159 cycles.
- 8E1 loopback (serialOutput→serialInput), send 0x07 then 0x00 back-to-back → parity bits 1 then 0; no gap between frames; rx_data = 0x07 then 0x00; both error flags 0.
- 7O2, DIV=3: send 0x7F → frame of 11 bits, 48 clocks each; RX decodes 0x7F.
- Inject a 0xC3 frame with stop bit 0, then hold the line low for 40 bits → single rx_valid with rx_data=0xC3 and rx_frame_err=1; no further rx_valid until the line has been high and a new start bit arrives.
- Low glitch of OVERSAMPLE/2−1 ticks on an idle line → no rx_valid. A corrupted parity bit on an 8E1 frame → rx_parity_err=1.
- Assert reset_n low mid-TX and mid-RX → serialOutput=1 and tx_ready=1 asynchronously; no rx_valid; a clean frame after release is received correctly.

Source files
------------

// File: rtl/uart_param_if.sv
// Byte-side handshake and serial pin bundle for uart_param.
// The master side is the system (bench); the slave side is the UART core.
interface uart_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 serialOutput;
    logic                 serialInput;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_valid, tx_data, serialInput,
        input  tx_ready, serialOutput, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_valid, tx_data, serialInput,
        output tx_ready, serialOutput, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: ready/valid transmitter with clock-counted bit
// timing, oversampling receiver with parity/framing checks and break handling.
module uart_param #(
    parameter int DIV        = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input logic         clk,
    input logic         reset_n,
    uart_param_if.slave bus
);
    localparam int   BIT_CLKS  = DIV * OVERSAMPLE;
    localparam int   STOP_CLKS = STOP_BITS * BIT_CLKS;
    localparam int   TX_CW     = $clog2(STOP_CLKS + 1);
    localparam int   RX_CW     = $clog2(OVERSAMPLE + 1);
    localparam int   BIT_W     = $clog2(DATA_BITS + 1);
    localparam int   DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t            r_tx_state;
    logic [TX_CW-1:0]     r_tx_cnt;
    logic [BIT_W-1:0]     r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_line;
    logic                 r_tx_ready;
    logic                 w_tx_bit_end;
    logic                 w_tx_hs;

    assign w_tx_bit_end = (r_tx_cnt == TX_CW'(BIT_CLKS - 1));
    assign w_tx_hs      = bus.tx_valid && r_tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: ;
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == BIT_W'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                r_tx_line  <= r_tx_par;
                                r_tx_state <= TX_PARITY;
                            end else begin
                                r_tx_line  <= 1'b1;
                                r_tx_state <= TX_STOP;
                            end
                        end else begin
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_line  <= r_tx_shift[1];
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_line  <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == TX_CW'(STOP_CLKS - 1)) begin
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        // Ready one clock early so a new word can chain with no idle gap.
                        if (r_tx_cnt == TX_CW'(STOP_CLKS - 2)) r_tx_ready <= 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase

            // Ready is only high in IDLE or the last STOP clock; a handshake overrides both.
            if (w_tx_hs) begin
                r_tx_shift <= bus.tx_data;
                r_tx_par   <= (^bus.tx_data) ^ PAR_ODD;
                r_tx_line  <= 1'b0;
                r_tx_ready <= 1'b0;
                r_tx_cnt   <= '0;
                r_tx_state <= TX_START;
            end
        end
    end

    assign bus.tx_ready     = r_tx_ready;
    assign bus.serialOutput = r_tx_line;

    // ---------------- oversample tick ----------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else r_div_cnt <= r_div_cnt + 1'b1;
    end

    // ---------------- receiver ----------------
    logic [1:0]           r_sync;
    logic                 w_rx;
    rx_state_t            r_rx_state;
    logic [RX_CW-1:0]     r_rx_cnt;
    logic [BIT_W-1:0]     r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;
    logic                 w_rx_mid;

    assign w_rx     = r_sync[1];
    assign w_rx_mid = w_tick && (r_rx_cnt == RX_CW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= 2'b11;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], bus.serialInput};
            r_rx_valid <= 1'b0;
            if ((r_rx_state != RX_IDLE) && (r_rx_state != RX_BREAK) && w_tick && !w_rx_mid)
                r_rx_cnt <= r_rx_cnt + 1'b1;

            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rx) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Half-bit check rejects short low glitches and centres later samples.
                    if (w_tick && (r_rx_cnt == RX_CW'(OVERSAMPLE / 2 - 1))) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_rx_mid) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == BIT_W'(DATA_BITS - 1))
                            r_rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (w_rx_mid) begin
                        r_rx_cnt   <= '0;
                        r_rx_par   <= w_rx;
                        r_rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_rx_mid) begin
                        r_rx_cnt   <= '0;
                        r_rx_data  <= r_rx_shift;
                        r_rx_perr  <= (PARITY != 0) && (r_rx_par != ((^r_rx_shift) ^ PAR_ODD));
                        r_rx_ferr  <= !w_rx;
                        r_rx_valid <= 1'b1;
                        r_rx_state <= w_rx ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    if (w_rx) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_parity_err = r_rx_perr;
    assign bus.rx_frame_err  = r_rx_ferr;
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: 8N1/DIV1 with injected line, 8E1 loopback,
// 7O2/DIV3 loopback; frames, parity, break, glitch and reset behaviour.
module tb_uart_param;
    logic clk = 1'b0;
    logic reset_n;
    logic line1, line2, loop2;
    int   compared, mismatched;

    always #5 clk = ~clk;

    uart_param_if #(.DATA_BITS(8)) if1 ();
    uart_param_if #(.DATA_BITS(8)) if2 ();
    uart_param_if #(.DATA_BITS(7)) if3 ();

    assign if1.serialInput = line1;
    assign if2.serialInput = loop2 ? if2.serialOutput : line2;
    assign if3.serialInput = if3.serialOutput;

    uart_param #(.DIV(1), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_d1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    uart_param #(.DIV(1), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_d2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    uart_param #(.DIV(3), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
        u_d3 (.clk(clk), .reset_n(reset_n), .bus(if3));

    // receive monitors, sampled mid-cycle
    int       rx1_cnt = 0, rx2_cnt = 0, rx3_cnt = 0;
    logic [7:0] rx1_data;
    logic       rx1_perr, rx1_ferr;
    logic [7:0] rx2_data [0:15];
    logic       rx2_perr [0:15];
    logic       rx2_ferr [0:15];
    logic [6:0] rx3_data;
    logic       rx3_perr, rx3_ferr;

    always @(negedge clk) begin
        if (if1.rx_valid === 1'b1) begin
            rx1_cnt  <= rx1_cnt + 1;
            rx1_data <= if1.rx_data;
            rx1_perr <= if1.rx_parity_err;
            rx1_ferr <= if1.rx_frame_err;
        end
        if (if2.rx_valid === 1'b1) begin
            rx2_cnt <= rx2_cnt + 1;
            rx2_data[rx2_cnt[3:0]] <= if2.rx_data;
            rx2_perr[rx2_cnt[3:0]] <= if2.rx_parity_err;
            rx2_ferr[rx2_cnt[3:0]] <= if2.rx_frame_err;
        end
        if (if3.rx_valid === 1'b1) begin
            rx3_cnt  <= rx3_cnt + 1;
            rx3_data <= if3.rx_data;
            rx3_perr <= if3.rx_parity_err;
            rx3_ferr <= if3.rx_frame_err;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive n bits LSB first, 16 clocks each, onto line1 (sel=1) or line2.
    task automatic inject_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 1) line1 = bits[i];
            else line2 = bits[i];
            step(16);
        end
    endtask

    task automatic test_reset();
        step(2);
        compared++; if (if1.serialOutput !== 1'b1) begin mismatched++; $display("FAIL reset_line: got %b expected 1", if1.serialOutput); end
        compared++; if (if1.tx_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", if1.tx_ready); end
        compared++; if (if1.rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rxvalid: got %b expected 0", if1.rx_valid); end
        compared++; if (if1.rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_rxdata: got %h expected 00", if1.rx_data); end
        compared++; if (if1.rx_parity_err !== 1'b0) begin mismatched++; $display("FAIL reset_perr: got %b expected 0", if1.rx_parity_err); end
        compared++; if (if1.rx_frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_ferr: got %b expected 0", if1.rx_frame_err); end
        reset_n = 1'b1;
        step(3);
        compared++; if ({if1.serialOutput, if1.tx_ready, if3.tx_ready} !== 3'b111) begin mismatched++; $display("FAIL post_reset_idle: got %b expected 111", {if1.serialOutput, if1.tx_ready, if3.tx_ready}); end
    endtask

    task automatic test_tx_8n1();
        logic [9:0] exp_bits;
        logic       samp [0:159];
        int         low_cnt;
        logic       ready_last, ok, idle_ok;
        exp_bits = 10'b1101001010;
        if1.tx_data = 8'hA5; if1.tx_valid = 1'b1;
        step(1);
        if1.tx_valid = 1'b0;
        low_cnt = 0; ready_last = 1'b0;
        for (int k = 0; k < 160; k++) begin
            if (k == 50) begin if1.tx_valid = 1'b1; if1.tx_data = 8'h00; end
            if (k == 53) if1.tx_valid = 1'b0;
            samp[k] = if1.serialOutput;
            if (if1.tx_ready === 1'b0) low_cnt++;
            if (k == 159) ready_last = if1.tx_ready;
            step(1);
        end
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int j = 0; j < 16; j++) if (samp[16*b+j] !== exp_bits[b]) ok = 1'b0;
            compared++;
            if (!ok) begin mismatched++; $display("FAIL tx8n1_bit%0d: got %b (first clk) expected %b for 16 clocks", b, samp[16*b], exp_bits[b]); end
        end
        compared++; if (low_cnt != 159) begin mismatched++; $display("FAIL tx8n1_ready_low: got %0d expected 159", low_cnt); end
        compared++; if (ready_last !== 1'b1) begin mismatched++; $display("FAIL tx8n1_ready_stop_last: got %b expected 1", ready_last); end
        idle_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (if1.serialOutput !== 1'b1 || if1.tx_ready !== 1'b1) idle_ok = 1'b0;
            step(1);
        end
        compared++; if (!idle_ok) begin mismatched++; $display("FAIL tx8n1_busy_valid_ignored: got %b expected 1", idle_ok); end
    endtask

    task automatic test_back_to_back();
        logic samp [0:379];
        int   hs2_k;
        hs2_k = -1;
        if2.tx_data = 8'h07; if2.tx_valid = 1'b1;
        step(1);
        if2.tx_data = 8'h00;
        for (int k = 0; k < 380; k++) begin
            if (hs2_k >= 0 && k == hs2_k) if2.tx_valid = 1'b0;
            samp[k] = if2.serialOutput;
            if (hs2_k < 0 && if2.tx_ready === 1'b1) hs2_k = k + 1;
            step(1);
        end
        if2.tx_valid = 1'b0;
        compared++; if (hs2_k != 176) begin mismatched++; $display("FAIL b2b_second_handshake: got %0d expected 176", hs2_k); end
        compared++; if (samp[152] !== 1'b1) begin mismatched++; $display("FAIL b2b_parity0x07: got %b expected 1", samp[152]); end
        compared++; if ({samp[175], samp[176]} !== 2'b10) begin mismatched++; $display("FAIL b2b_no_gap: got %b expected 10", {samp[175], samp[176]}); end
        compared++; if (samp[328] !== 1'b0) begin mismatched++; $display("FAIL b2b_parity0x00: got %b expected 0", samp[328]); end
        compared++; if (rx2_cnt != 2) begin mismatched++; $display("FAIL b2b_rx_count: got %0d expected 2", rx2_cnt); end
        compared++; if (rx2_data[0] !== 8'h07) begin mismatched++; $display("FAIL b2b_rx_data0: got %h expected 07", rx2_data[0]); end
        compared++; if (rx2_data[1] !== 8'h00) begin mismatched++; $display("FAIL b2b_rx_data1: got %h expected 00", rx2_data[1]); end
        compared++; if ({rx2_perr[0], rx2_ferr[0], rx2_perr[1], rx2_ferr[1]} !== 4'b0000) begin mismatched++; $display("FAIL b2b_rx_errs: got %b expected 0000", {rx2_perr[0], rx2_ferr[0], rx2_perr[1], rx2_ferr[1]}); end
    endtask

    task automatic test_7o2_div3();
        logic [10:0] exp_bits;
        int          low_cnt, bad_bit;
        exp_bits = 11'b11011111110;
        bad_bit = -1; low_cnt = 0;
        if3.tx_data = 7'h7F; if3.tx_valid = 1'b1;
        step(1);
        if3.tx_valid = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (k < 528 && (k % 48) == 24 && if3.serialOutput !== exp_bits[k/48] && bad_bit < 0) bad_bit = k / 48;
            if (if3.tx_ready === 1'b0) low_cnt++;
            step(1);
        end
        compared++; if (bad_bit != -1) begin mismatched++; $display("FAIL tx7o2_bits: got first bad bit %0d expected none (-1)", bad_bit); end
        compared++; if (low_cnt != 527) begin mismatched++; $display("FAIL tx7o2_ready_low: got %0d expected 527", low_cnt); end
        compared++; if (rx3_cnt != 1) begin mismatched++; $display("FAIL rx7o2_count: got %0d expected 1", rx3_cnt); end
        compared++; if (rx3_data !== 7'h7F) begin mismatched++; $display("FAIL rx7o2_data: got %h expected 7f", rx3_data); end
        compared++; if ({rx3_perr, rx3_ferr} !== 2'b00) begin mismatched++; $display("FAIL rx7o2_errs: got %b expected 00", {rx3_perr, rx3_ferr}); end
    endtask

    task automatic test_glitch();
        int base;
        base = rx1_cnt;
        line1 = 1'b0;
        step(7);
        line1 = 1'b1;
        step(40);
        compared++; if (rx1_cnt != base) begin mismatched++; $display("FAIL glitch_no_valid: got %0d expected %0d", rx1_cnt, base); end
    endtask

    task automatic test_break();
        int base;
        base = rx1_cnt;
        inject_bits(1, 16'h0186, 10);
        line1 = 1'b0;
        step(640);
        compared++; if (rx1_cnt != base + 1) begin mismatched++; $display("FAIL break_single_valid: got %0d expected %0d", rx1_cnt, base + 1); end
        compared++; if (rx1_data !== 8'hC3) begin mismatched++; $display("FAIL break_data: got %h expected c3", rx1_data); end
        compared++; if ({rx1_ferr, rx1_perr} !== 2'b10) begin mismatched++; $display("FAIL break_flags: got %b expected 10", {rx1_ferr, rx1_perr}); end
        line1 = 1'b1;
        step(32);
        compared++; if (rx1_cnt != base + 1) begin mismatched++; $display("FAIL break_release: got %0d expected %0d", rx1_cnt, base + 1); end
        inject_bits(1, 16'h02B4, 10);
        step(20);
        compared++; if (rx1_cnt != base + 2) begin mismatched++; $display("FAIL after_break_count: got %0d expected %0d", rx1_cnt, base + 2); end
        compared++; if ({rx1_data, rx1_ferr} !== {8'h5A, 1'b0}) begin mismatched++; $display("FAIL after_break_frame: got %h/%b expected 5a/0", rx1_data, rx1_ferr); end
    endtask

    task automatic test_parity_err();
        int base;
        base = rx2_cnt;
        line2 = 1'b1; loop2 = 1'b0;
        step(2);
        inject_bits(2, 16'h040E, 11);
        step(20);
        loop2 = 1'b1;
        compared++; if (rx2_cnt != base + 1) begin mismatched++; $display("FAIL perr_count: got %0d expected %0d", rx2_cnt, base + 1); end
        compared++; if (rx2_data[base[3:0]] !== 8'h07) begin mismatched++; $display("FAIL perr_data: got %h expected 07", rx2_data[base[3:0]]); end
        compared++; if ({rx2_perr[base[3:0]], rx2_ferr[base[3:0]]} !== 2'b10) begin mismatched++; $display("FAIL perr_flags: got %b expected 10", {rx2_perr[base[3:0]], rx2_ferr[base[3:0]]}); end
    endtask

    task automatic test_reset_mid();
        int base;
        base = rx1_cnt;
        if1.tx_data = 8'h00; if1.tx_valid = 1'b1;
        step(1);
        if1.tx_valid = 1'b0;
        inject_bits(1, 16'h02B4, 5);
        compared++; if (if1.serialOutput !== 1'b0) begin mismatched++; $display("FAIL midtx_line_before_reset: got %b expected 0", if1.serialOutput); end
        #2 reset_n = 1'b0;
        #1;
        compared++; if ({if1.serialOutput, if1.tx_ready} !== 2'b11) begin mismatched++; $display("FAIL async_reset_tx: got %b expected 11", {if1.serialOutput, if1.tx_ready}); end
        compared++; if ({if1.rx_valid, if1.rx_data} !== 9'h000) begin mismatched++; $display("FAIL async_reset_rx: got %h expected 000", {if1.rx_valid, if1.rx_data}); end
        line1 = 1'b1;
        step(5);
        reset_n = 1'b1;
        step(200);
        compared++; if (rx1_cnt != base) begin mismatched++; $display("FAIL reset_no_partial_valid: got %0d expected %0d", rx1_cnt, base); end
        compared++; if (if1.serialOutput !== 1'b1) begin mismatched++; $display("FAIL reset_tx_aborted: got %b expected 1", if1.serialOutput); end
        inject_bits(1, 16'h0278, 10);
        step(20);
        compared++; if (rx1_cnt != base + 1) begin mismatched++; $display("FAIL post_reset_count: got %0d expected %0d", rx1_cnt, base + 1); end
        compared++; if ({rx1_data, rx1_perr, rx1_ferr} !== {8'h3C, 2'b00}) begin mismatched++; $display("FAIL post_reset_frame: got %h/%b%b expected 3c/00", rx1_data, rx1_perr, rx1_ferr); end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        reset_n = 1'b0;
        line1 = 1'b1; line2 = 1'b1; loop2 = 1'b1;
        if1.tx_valid = 1'b0; if1.tx_data = '0;
        if2.tx_valid = 1'b0; if2.tx_data = '0;
        if3.tx_valid = 1'b0; if3.tx_data = '0;
        step(1);
        test_reset();
        test_tx_8n1();
        test_back_to_back();
        test_7o2_div3();
        test_glitch();
        test_break();
        test_parity_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
